// File: rtl/srt_radix4_divider.sv
// rtl/srt_radix4_divider.sv - multi-cycle radix-4 SRT significand divider
// Digit set {-3,-1,+1,+3}, on-the-fly quotient conversion, one final correction.
module srt_radix4_divider #(
  parameter int WIDTH = 24,
  parameter int ITERS = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       dividend,
  input  logic [WIDTH-1:0]       divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*ITERS-1:0]     quotient,
  output logic [WIDTH:0]         remainder,
  output logic                   div_err
);

  localparam int QW = 2 * ITERS;
  localparam int RW = WIDTH + 4;
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t               state;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] d2;
  logic [QW-1:0]        q_reg;
  logic [QW-1:0]        qm_reg;
  logic [CW-1:0]        cnt;

  logic signed [RW-1:0] w;
  logic signed [RW-1:0] d2x2;
  logic signed [RW-1:0] d2x3;
  logic signed [RW-1:0] r_next;
  logic [QW-1:0]        q_next;
  logic [QW-1:0]        qm_next;

  assign w    = r <<< 2;
  assign d2x2 = d2 <<< 1;
  assign d2x3 = d2 + d2x2;

  // Exact range compare picks the digit; appending two bits to Q or QM
  // realises 4Q+q / 4QM+4+q without any carry-propagating add.
  always_comb begin
    r_next  = w;
    q_next  = q_reg;
    qm_next = qm_reg;
    if (w >= d2x2) begin
      r_next  = w - d2x3;
      q_next  = {q_reg[QW-3:0], 2'b11};
      qm_next = {q_reg[QW-3:0], 2'b10};
    end else if (!w[RW-1]) begin
      r_next  = w - d2;
      q_next  = {q_reg[QW-3:0], 2'b01};
      qm_next = {q_reg[QW-3:0], 2'b00};
    end else if (w >= -d2x2) begin
      r_next  = w + d2;
      q_next  = {qm_reg[QW-3:0], 2'b11};
      qm_next = {qm_reg[QW-3:0], 2'b10};
    end else begin
      r_next  = w + d2x3;
      q_next  = {qm_reg[QW-3:0], 2'b01};
      qm_next = {qm_reg[QW-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_err   <= 1'b0;
      r         <= '0;
      d2        <= '0;
      q_reg     <= '0;
      qm_reg    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor[WIDTH-1]) begin
              d2      <= {3'b000, divisor, 1'b0};
              r       <= {4'b0000, dividend};
              q_reg   <= '0;
              qm_reg  <= '0;
              cnt     <= CW'(ITERS - 1);
              div_err <= 1'b0;
              state   <= ITER;
            end else begin
              quotient  <= '1;
              remainder <= '0;
              div_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ITER: begin
          r      <= r_next;
          q_reg  <= q_next;
          qm_reg <= qm_next;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) state <= CORR;
        end
        CORR: begin
          // Low WIDTH+1 bits suffice: the corrected remainder is below 2D.
          if (r[RW-1]) begin
            quotient  <= qm_reg;
            remainder <= r[WIDTH:0] + d2[WIDTH:0];
          end else begin
            quotient  <= q_reg;
            remainder <= r[WIDTH:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/srt_radix4_divider.md
Name: srt_radix4_divider

Overview:
- Parametrised, multi-cycle radix-4 SRT significand divider with a valid/ready handshake on both input and output.
- Each cycle it selects one quotient digit by exact range comparison of the partial remainder against 1x and 2x the working divisor, using the non-redundant odd digit set {-3,-1,+1,+3}.
- Quotient digits are assembled by on-the-fly conversion, followed by a single final negative-remainder correction step.
- Sits behind operand unpacking in the FP divide path; it is the sequential successor to the combinational remainder/divisor range check.

Parameters:
- WIDTH, 24, significand width of the dividend and divisor.
- ITERS, 13, number of radix-4 iterations; quotient width is QW = 2*ITERS (localparam).
- Internal remainder width is RW = WIDTH+4, signed two's complement (localparam).

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept operands.
- dividend  in  WIDTH  X, unsigned, any value.
- divisor  in  WIDTH  D, unsigned; must be normalised (MSB = 1).
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- quotient  out  QW  Q = floor(X*4^ITERS / (2D)).
- remainder  out  WIDTH+1  R = X*4^ITERS - Q*2D, with 0 <= R < 2D.
- div_err  out  1  divisor was not normalised, including D = 0.

Behaviour:
- Reset:
  - state = IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_err = 0.
  - All internal registers (r, Q, QM, D2, counter) are cleared.
  - Reset mid-operation abandons the division; no result is produced.
- States and transitions:
  - IDLE -> ITER on in_valid && in_ready with divisor[WIDTH-1] = 1.
  - IDLE -> DONE directly with divisor[WIDTH-1] = 0.
  - ITER -> CORR after the ITERS-th iteration.
  - CORR -> DONE.
  - DONE -> IDLE on out_ready.
- in_ready = 1 only in IDLE. Operands are captured on the accept edge; later changes on dividend/divisor are ignored.
- Init on accept:
  - D2 = 2*D, r0 = X (sign-extended to RW bits).
  - Q = 0, QM = 0, counter = ITERS-1.
  - Invariant: -D2 <= r < D2.
- ITER, once per cycle:
  - w = 4*r.
  - Digit select: w >= 2*D2 -> q = +3; 0 <= w < 2*D2 -> q = +1; -2*D2 <= w < 0 -> q = -1; w < -2*D2 -> q = -3.
  - Remainder update: r' = w - q*D2, which always lands in [-D2, D2). 3*D2 is computed as D2 + 2*D2.
  - On-the-fly conversion, q > 0: Q' = 4Q + q, QM' = 4Q + q - 1.
  - On-the-fly conversion, q < 0: Q' = 4QM + 4 + q, QM' = 4QM + 3 + q.
  - Counter decrements each cycle; ITER exits when the counter is 0.
- CORR:
  - If r < 0: quotient = QM, remainder = r + D2.
  - Else: quotient = Q, remainder = r.
  - Enter DONE with out_valid = 1.
- Error path (unnormalised divisor): quotient = all ones, remainder = 0, div_err = 1, out_valid = 1 on the cycle after accept.
- Latency:
  - Normal: out_valid asserts ITERS+2 clocks after the accept edge (15 cycles at the defaults).
  - Error: 1 clock.
- Output hold:
  - quotient, remainder and div_err are stable while out_valid && !out_ready.
  - out_valid drops on the clock edge where out_ready is sampled high; the next operand can be accepted one cycle later.
  - div_err clears when the next operand is accepted.
- Arithmetic: r needs no overflow detection given the invariant. Intermediate Q/QM wrap modulo 2^QW, and the final result is exact.

Test Plan:
- X = 0x800000, D = 0x800000 -> quotient = 33554432 (2^25), remainder = 0, div_err = 0; out_valid exactly 15 cycles after accept.
- X = 0xFFFFFF, D = 0x800000 -> quotient = 67108860, remainder = 0.
- X = 0x400000, D = 0xC00000 -> quotient = 11184810, remainder = 16777216 (exercises the negative-digit and CORR paths).
- X = 0x000000, D = 0x800000 -> quotient = 0, remainder = 0 (final remainder negative, correction applied).
- D = 0x000001 (and D = 0) -> div_err = 1, quotient = 0x3FFFFFF, remainder = 0, out_valid one cycle after accept.
- Back-pressure and reset:
  - Hold out_ready = 0 for 5 cycles after out_valid -> outputs unchanged and in_ready = 0 throughout.
  - Assert rst at iteration 6 -> out_valid = 0 and in_ready = 1 immediately; the next division returns the correct result.
